// File: rtl/pll_lock_ctrl.sv
`timescale 1ns/1ps
// pll_lock_ctrl: PLL supervisor clocked by the free-running reference clkin.
// Generates the PLL RST power-up pulse, synchronises the raw LOCK pin,
// qualifies lock over a stable window, counts lock losses, and handles
// lock timeout. Optional feature macro: PLL_LOCK_RETRY_EN (timeout retries
// the PLL instead of parking in FAIL).
module pll_lock_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int CNT_W        = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             locked,
  output logic             pll_rst,
  output logic             clklocked,
  output logic             pll_fail,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  // Shared phase counter is sized to hold the largest limit of any state.
  localparam int MAX_RS  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_ALL = (MAX_RS > LOCK_TIMEOUT) ? MAX_RS : LOCK_TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0]    RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EVT_MAX      = '1;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  logic                   pll_rst_q, pll_rst_d;
  logic                   clklocked_q, clklocked_d;
  logic                   pll_fail_q, pll_fail_d;
  logic [CNT_W-1:0]       lost_q, lost_d;
`ifdef PLL_LOCK_RETRY_EN
  logic [CNT_W-1:0]       retry_q, retry_d;
`endif

  // Shift raw lock into the synchroniser chain; the last stage is lock_s.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], locked};
    lock_s = sync_q[SYNC_STAGES-1];
  end

  // Next-state, shared counter, event counters and registered outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in combinational logic infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    lost_d  = lost_q;
`ifdef PLL_LOCK_RETRY_EN
    retry_d = retry_q;
`endif

    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Lock has priority over a timeout landing on the same edge.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
`ifdef PLL_LOCK_RETRY_EN
          state_d = ST_RST;
          if (retry_q != EVT_MAX) retry_d = retry_q + CNT_W'(1);
`else
          state_d = ST_FAIL;
`endif
        end
      end
      ST_STABLE: begin
        // A drop before qualification is a glitch, not a counted loss.
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Unbounded dwell: hold the counter so it never wraps.
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = ST_WAIT;
          if (lost_q != EVT_MAX) lost_d = lost_q + CNT_W'(1);
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs are registered from the next state so they line up with state_q.
    pll_rst_d   = (state_d == ST_RST);
    clklocked_d = (state_d == ST_LOCKED);
    pll_fail_d  = (state_d == ST_FAIL);
  end

  // State, counter, synchroniser and output registers; asynchronous reset.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      clklocked_q <= 1'b0;
      pll_fail_q  <= 1'b0;
      lost_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      clklocked_q <= clklocked_d;
      pll_fail_q  <= pll_fail_d;
      lost_q      <= lost_d;
    end
  end

`ifdef PLL_LOCK_RETRY_EN
  // Saturating retry counter, only present when retry is enabled.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end

  assign retry_cnt = retry_q;
`else
  assign retry_cnt = '0;
`endif

  assign state     = state_q;
  assign pll_rst   = pll_rst_q;
  assign clklocked = clklocked_q;
  assign pll_fail  = pll_fail_q;
  assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
`timescale 1ns/1ps
// tb_pll_lock_ctrl: directed bench for pll_lock_ctrl with a phase/elapsed
// reference model compared every cycle, plus hand-computed edge counts.
module tb_pll_lock_ctrl;

  localparam int SYNC    = 2;
  localparam int RSTC    = 4;
  localparam int STB     = 8;
  localparam int TMO     = 32;
  localparam int CW      = 4;
  localparam int EVT_MAX = (1 << CW) - 1;

  localparam int P_RST    = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_LOCKED = 3;
  localparam int P_FAIL   = 4;

  logic          clkin  = 1'b0;
  logic          reset  = 1'b1;
  logic          locked = 1'b0;
  logic          pll_rst;
  logic          clklocked;
  logic          pll_fail;
  logic [2:0]    state;
  logic [CW-1:0] lost_cnt;
  logic [CW-1:0] retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: which phase the supervisor is in, how many edges it has
  // spent there, and the raw-lock history seen through the synchroniser delay.
  int m_ph    = P_RST;
  int m_el    = 0;
  int m_lost  = 0;
  int m_retry = 0;
  bit m_hist[$];

  pll_lock_ctrl #(
    .SYNC_STAGES (SYNC),
    .RST_CYCLES  (RSTC),
    .LOCK_STABLE (STB),
    .LOCK_TIMEOUT(TMO),
    .CNT_W       (CW)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .locked   (locked),
    .pll_rst  (pll_rst),
    .clklocked(clklocked),
    .pll_fail (pll_fail),
    .state    (state),
    .lost_cnt (lost_cnt),
    .retry_cnt(retry_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic enter(input int ph);
    m_ph = ph;
    m_el = 0;
  endtask

  // Model update on every clock edge, immediate on reset assertion.
  initial forever begin
    bit ls;
    @(posedge clkin or posedge reset);
    if (reset) begin
      m_ph = P_RST; m_el = 0; m_lost = 0; m_retry = 0;
      m_hist.delete();
      repeat (SYNC) m_hist.push_back(1'b0);
    end else begin
      m_hist.push_front(locked);
      ls = m_hist[SYNC];
      void'(m_hist.pop_back());
      m_el++;
      case (m_ph)
        P_RST:    if (m_el == RSTC) enter(P_WAIT);
        P_WAIT: begin
          if (ls) enter(P_STABLE);
          else if (m_el == TMO) begin
`ifdef PLL_LOCK_RETRY_EN
            enter(P_RST);
            if (m_retry < EVT_MAX) m_retry++;
`else
            enter(P_FAIL);
`endif
          end
        end
        P_STABLE: begin
          if (!ls) enter(P_WAIT);
          else if (m_el == STB) enter(P_LOCKED);
        end
        P_LOCKED: begin
          if (!ls) begin
            enter(P_WAIT);
            if (m_lost < EVT_MAX) m_lost++;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare all outputs against the model mid-cycle.
  initial forever begin
    @(negedge clkin);
    if (chk_en) begin
      check("m_state",     state,     m_ph);
      check("m_pll_rst",   pll_rst,   m_ph == P_RST);
      check("m_clklocked", clklocked, m_ph == P_LOCKED);
      check("m_pll_fail",  pll_fail,  m_ph == P_FAIL);
      check("m_lost_cnt",  lost_cnt,  m_lost);
      check("m_retry_cnt", retry_cnt, m_retry);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset  = 1'b1;
    locked = 1'b0;
    tick(3);
    chk_en = 1'b1;
    check("rst_state",     state,     P_RST);
    check("rst_pll_rst",   pll_rst,   1);
    check("rst_clklocked", clklocked, 0);
    check("rst_lost",      lost_cnt,  0);

    // Power-up pulse: RST for exactly RSTC edges after release.
    reset = 1'b0;
    n = 0;
    while (pll_rst && n < 20) begin tick(1); n++; end
    check("rst_pulse_edges", n, RSTC);
    check("wait_after_rst",  state, P_WAIT);
    check("wait_clklocked",  clklocked, 0);

    // Lock arrives 10 cycles into WAIT, then a 3-cycle glitch in STABLE.
    tick(9);
    locked = 1'b1;
    n = 0;
    while (state != P_STABLE && n < 20) begin tick(1); n++; end
    check("lock_to_stable_edges", n, SYNC + 1);
    tick(5);
    locked = 1'b0;
    tick(3);
    check("glitch_to_wait", state, P_WAIT);
    locked = 1'b1;
    n = 0;
    while (!clklocked && n < 40) begin tick(1); n++; end
    check("requal_edges", n, SYNC + STB + 1);
    check("glitch_lost",  lost_cnt, 0);

    // Repeated loss of lock from LOCKED; counter saturates at EVT_MAX.
    for (int i = 0; i < 25; i++) begin
      locked = 1'b0;
      n = 0;
      while (clklocked && n < 20) begin tick(1); n++; end
      check("loss_fall_edges", n, 3);
      tick(20 - n);
      locked = 1'b1;
      n = 0;
      while (!clklocked && n < 40) begin tick(1); n++; end
      check("loss_rise_edges", n, SYNC + STB + 1);
      if (i == 4) check("lost_after_5", lost_cnt, 5);
    end
    check("lost_saturated", lost_cnt, EVT_MAX);

    // Lock seen on the same edge as the WAIT timeout: lock wins.
    locked = 1'b0;
    tick(32);
    locked = 1'b1;
    tick(2);
    check("coincide_pre_state", state, P_WAIT);
    tick(1);
    check("coincide_state", state,     P_STABLE);
    check("coincide_fail",  pll_fail,  0);
    check("coincide_retry", retry_cnt, 0);

    // Asynchronous reset mid-STABLE takes effect before the next edge.
    tick(3);
    reset = 1'b1;
    #1;
    check("midrst_state",     state,     P_RST);
    check("midrst_pll_rst",   pll_rst,   1);
    check("midrst_clklocked", clklocked, 0);
    check("midrst_pll_fail",  pll_fail,  0);
    check("midrst_lost",      lost_cnt,  0);
    check("midrst_retry",     retry_cnt, 0);
    locked = 1'b0;
    tick(2);
    reset = 1'b0;

    // Lock never arrives: timeout behaviour over 200 cycles.
`ifdef PLL_LOCK_RETRY_EN
    n = 0;
    while (n < 100) begin
      tick(1); n++;
      if (n > RSTC && pll_rst) break;
    end
    check("first_retry_edge", n, RSTC + TMO);
    check("retry_after_1",    retry_cnt, 1);
    tick(200 - n);
    check("retry_after_200",  retry_cnt, 5);
    check("retry_state_200",  state, P_WAIT);
    check("retry_no_fail",    pll_fail, 0);
`else
    n = 0;
    while (!pll_fail && n < 100) begin tick(1); n++; end
    check("fail_edge",       n, RSTC + TMO);
    check("fail_state",      state, P_FAIL);
    check("fail_pll_rst",    pll_rst, 0);
    check("fail_retry",      retry_cnt, 0);
    tick(200 - n);
    check("fail_terminal",   state, P_FAIL);
    check("fail_still_high", pll_fail, 1);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
